// File: rtl/snn_noc_pkg.sv
// snn_noc_pkg: shared defaults and FSM encoding for the spike dispatch path
package snn_noc_pkg;
  localparam int DEF_NUM_NEURONS = 10;
  localparam int DEF_ADDR_W = 12;
  localparam int DEF_PTR_W = 5;
  localparam int DEF_TABLE_DEPTH = 30;
  typedef enum logic [1:0] {IDLE, LOOKUP, SEND} state_t;
endpackage

// File: rtl/spike_dispatch_scheduler_if.sv
// spike_dispatch_scheduler_if: outgoing spike packet valid/ready channel
interface spike_dispatch_scheduler_if #(parameter int ADDR_W = snn_noc_pkg::DEF_ADDR_W) ();
  logic pkt_valid;
  logic pkt_ready;
  logic [ADDR_W-1:0] pkt_src;
  logic [ADDR_W-1:0] pkt_dst;
  modport master (output pkt_valid, pkt_src, pkt_dst, input pkt_ready);
  modport slave (input pkt_valid, pkt_src, pkt_dst, output pkt_ready);
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant starting after the last advanced index
module rr_arbiter #(
  parameter int N = 10,
  parameter int IW = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [N-1:0] req,
  input  logic adv,
  output logic [N-1:0] gnt,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] last_q;
  logic [N-1:0] rot;
  int off, sum;
  // rotate so bit 0 is the neuron right after the last grant, then pick the lowest set bit
  always_comb begin
    rot = N'({req, req} >> (int'(last_q) + 1));
    off = 0;
    for (int k = N - 1; k >= 0; k--) if (rot[k]) off = k;
    sum = int'(last_q) + 1 + off;
    idx = IW'(sum >= N ? sum - N : sum);
    gnt = |req ? N'(1) << idx : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_q <= IW'(N - 1);
    else if (adv) last_q <= idx;
endmodule

// File: rtl/spike_dispatch_scheduler.sv
// spike_dispatch_scheduler: latches spikes and emits one packet per downstream connection
module spike_dispatch_scheduler
  import snn_noc_pkg::*;
#(
  parameter int NUM_NEURONS = DEF_NUM_NEURONS,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int PTR_W = DEF_PTR_W,
  parameter int TABLE_DEPTH = DEF_TABLE_DEPTH
) (
  input  logic CLK,
  input  logic RESETn,
  input  logic clear,
  input  logic [NUM_NEURONS-1:0] spike_in,
  input  logic cfg_we,
  input  logic cfg_sel,
  input  logic [PTR_W-1:0] cfg_addr,
  input  logic [ADDR_W-1:0] cfg_data,
  spike_dispatch_scheduler_if.master pkt,
  output logic busy,
  output logic [NUM_NEURONS-1:0] pending
);
  localparam int IW = $clog2(NUM_NEURONS + 1);
  localparam int CW = $clog2(TABLE_DEPTH);
  state_t st_q, st_d;
  logic loaded_q, grant, xfer, cfg_ok;
  logic [IW-1:0] g_q, arb_idx;
  logic [PTR_W-1:0] idx_q, end_q, ptr_hi;
  logic [NUM_NEURONS-1:0] pending_q, gnt;
  logic [PTR_W-1:0] ptr [NUM_NEURONS+1];
  logic [ADDR_W-1:0] conn [TABLE_DEPTH];
  rr_arbiter #(.N(NUM_NEURONS), .IW(IW)) u_arb (
    .clk(CLK), .rst_n(RESETn), .req(pending_q), .adv(grant), .gnt(gnt), .idx(arb_idx)
  );
  assign grant = st_q == IDLE && !clear && |pending_q;
  assign cfg_ok = cfg_we && st_q == IDLE && !clear;
  assign ptr_hi = ptr[g_q + 1'b1];
  assign pkt.pkt_valid = st_q == SEND && !clear;
  assign pkt.pkt_src = pkt.pkt_valid ? ADDR_W'(g_q) : '0;
  assign pkt.pkt_dst = pkt.pkt_valid ? conn[CW'(idx_q)] : '0;
  assign xfer = pkt.pkt_valid && pkt.pkt_ready;
  assign busy = st_q != IDLE;
  assign pending = pending_q;
  // LOOKUP spends one cycle loading the range and decides on the next
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE:    if (|pending_q) st_d = LOOKUP;
      LOOKUP:  if (loaded_q) st_d = idx_q >= end_q ? IDLE : SEND;
      SEND:    if (xfer && idx_q + 1'b1 == end_q) st_d = IDLE;
      default: st_d = IDLE;
    endcase
    if (clear) st_d = IDLE;
  end
  always_ff @(posedge CLK or negedge RESETn)
    if (!RESETn) begin
      st_q <= IDLE;
      loaded_q <= 1'b0;
      g_q <= '0;
      idx_q <= '0;
      end_q <= '0;
      pending_q <= '0;
      ptr <= '{default: '0};
      conn <= '{default: '0};
    end else begin
      st_q <= st_d;
      pending_q <= clear ? '0 : (pending_q & ~(grant ? gnt : '0)) | spike_in;
      loaded_q <= st_q == LOOKUP && !loaded_q && !clear;
      if (grant) g_q <= arb_idx;
      if (st_q == LOOKUP && !loaded_q) begin
        idx_q <= ptr[g_q];
        end_q <= ptr_hi > PTR_W'(TABLE_DEPTH) ? PTR_W'(TABLE_DEPTH) : ptr_hi;
      end else if (xfer) idx_q <= idx_q + 1'b1;
      if (cfg_ok && !cfg_sel && int'(cfg_addr) < NUM_NEURONS + 1) ptr[IW'(cfg_addr)] <= cfg_data[PTR_W-1:0];
      if (cfg_ok && cfg_sel && int'(cfg_addr) < TABLE_DEPTH) conn[CW'(cfg_addr)] <= cfg_data;
    end
endmodule
